// File: rtl/dmem_pkg.sv
// Types and lane helpers for the data-memory responder.
`ifndef DMEM_DEFINES_SV
`include "define.sv"
`endif

package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    localparam logic [2:0] F3_LB  = `FN3_LB;
    localparam logic [2:0] F3_LH  = `FN3_LH;
    localparam logic [2:0] F3_LW  = `FN3_LW;
    localparam logic [2:0] F3_LBU = `FN3_LBU;
    localparam logic [2:0] F3_LHU = `FN3_LHU;
    localparam logic [2:0] F3_SB  = `FN3_SB;
    localparam logic [2:0] F3_SH  = `FN3_SH;
    localparam logic [2:0] F3_SW  = `FN3_SW;

    function automatic logic is_sub_store(input logic [2:0] funct3);
        return (funct3 == F3_SB) || (funct3 == F3_SH);
    endfunction

    // Reserved load encodings fall through to the full-word case.
    function automatic logic [`XLEN-1:0] lane_extract(input logic [`XLEN-1:0] word,
                                                      input logic [2:0]       funct3,
                                                      input logic [1:0]       off);
        logic [`XLEN-1:0] byte_sh;
        logic [`XLEN-1:0] half_sh;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (funct3)
            F3_LB:   return {{(`XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            F3_LBU:  return {{(`XLEN-8){1'b0}}, byte_sh[7:0]};
            F3_LH:   return {{(`XLEN-16){half_sh[15]}}, half_sh[15:0]};
            F3_LHU:  return {{(`XLEN-16){1'b0}}, half_sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [`XLEN-1:0] lane_merge(input logic [`XLEN-1:0] old,
                                                    input logic [`XLEN-1:0] wdata,
                                                    input logic [2:0]       funct3,
                                                    input logic [1:0]       off);
        logic [`XLEN-1:0] mask;
        logic [`XLEN-1:0] ins;
        case (funct3)
            F3_SB: begin
                mask = {{(`XLEN-8){1'b0}}, 8'hFF} << {off, 3'b000};
                ins  = {{(`XLEN-8){1'b0}}, wdata[7:0]} << {off, 3'b000};
                return (old & ~mask) | ins;
            end
            F3_SH: begin
                mask = {{(`XLEN-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
                ins  = {{(`XLEN-16){1'b0}}, wdata[15:0]} << {off[1], 4'b0000};
                return (old & ~mask) | ins;
            end
            default: return wdata;
        endcase
    endfunction

    function automatic logic is_fault(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
        if (!we) begin
            case (funct3)
                F3_LB, F3_LBU: return 1'b0;
                F3_LH, F3_LHU: return off[0];
                F3_LW:         return off != 2'b00;
                default:       return 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_SB:   return 1'b0;
                F3_SH:   return off[0];
                F3_SW:   return off != 2'b00;
                default: return 1'b1;
            endcase
        end
    endfunction

endpackage

// File: rtl/define.sv
// Shared core-wide defines: datapath width and RISC-V load/store funct3 codes.
`ifndef DMEM_DEFINES_SV
`define DMEM_DEFINES_SV

`define XLEN 32

`define FN3_LB  3'b000
`define FN3_LH  3'b001
`define FN3_LW  3'b010
`define FN3_LBU 3'b100
`define FN3_LHU 3'b101
`define FN3_SB  3'b000
`define FN3_SH  3'b001
`define FN3_SW  3'b010

`endif

// File: rtl/dmem_ram.sv
// Single-port word-wide synchronous RAM with a one-cycle registered read.
`ifndef DMEM_DEFINES_SV
`include "define.sv"
`endif

module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [`XLEN-1:0]  wdata_i,
    output logic [`XLEN-1:0]  rdata_o
);

    logic [`XLEN-1:0] mem_q [DEPTH];
    logic [`XLEN-1:0] rdata_q;

    // NOTE: storage arrays carry no reset; the parent guarantees no write during reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: byte-lane steering, sign extension and sub-word RMW.
// Optional misalignment/reserved-funct3 faults: define DMEM_MISALIGN_FAULT_EN.
`ifndef DMEM_DEFINES_SV
`include "define.sv"
`endif

module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [`XLEN-1:0] req_addr,
    input  logic [`XLEN-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [`XLEN-1:0] rsp_rdata,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic [`XLEN-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [AW+1:0]    addr_q;
    logic [2:0]       funct3_q;
    logic [`XLEN-1:0] wdata_q, wdata_d;

    logic             accept;
    logic             req_fault;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [`XLEN-1:0] ram_rdata;

    logic             unused_addr_hi;
    assign unused_addr_hi = ^req_addr[`XLEN-1:AW+2];

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_FAULT_EN
    assign req_fault = is_fault(req_we, req_funct3, req_addr[1:0]);
`else
    assign req_fault = 1'b0;
`endif

    // The read is launched in the accept cycle so data is ready one cycle later.
    assign ram_addr = (state_q == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr[AW+1:0];
            funct3_q <= req_funct3;
        end
        wdata_q <= wdata_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        ram_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    err_d   = req_fault;
                    wdata_d = req_wdata;
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (is_sub_store(req_funct3)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                rdata_d = lane_extract(ram_rdata, funct3_q, addr_q[1:0]);
                state_d = ST_RESP;
            end
            ST_WR: begin
                ram_we  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                wdata_d = lane_merge(ram_rdata, wdata_q, funct3_q, addr_q[1:0]);
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_we  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we && rst_n),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: lanes, RMW, backpressure, aliasing, faults, reset.
`timescale 1ns/1ps

module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

    dmem_responder #(.DEPTH(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge and return just after its acceptance edge.
    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic rdy, input string tag);
        @(negedge clk);
        check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        rsp_ready  = rdy;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wdata  = 32'h0BAD_0BAD;
        req_addr   = 32'hFFFF_FFFF;
    endtask

    task automatic transact(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int exp_lat, input logic [31:0] exp_rdata,
                            input logic exp_err, input int hold, input string tag);
        int lat;
        start_req(we, f3, addr, wdata, hold == 0, tag);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, ".hold_valid"}, {31'b0, rsp_valid}, 32'd1);
                check({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
                check({tag, ".hold_ready"}, {31'b0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold > 0) begin
            check({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
            check({tag, ".idle_valid"}, {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, ".rsp_err"},   {31'b0, rsp_err}, 32'd0);
        check({tag, ".req_ready"}, {31'b0, req_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Alignment and sign extension
        transact(1'b1, SW,  32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, "sw_10");
        transact(1'b0, LW,  32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, "lw_10");
        transact(1'b0, LB,  32'h11, 32'h0, 2, 32'hFFFFFFBE, 1'b0, 0, "lb_11");
        transact(1'b0, LBU, 32'h11, 32'h0, 2, 32'h000000BE, 1'b0, 0, "lbu_11");
        transact(1'b0, LH,  32'h12, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 0, "lh_12");
        transact(1'b0, LHU, 32'h10, 32'h0, 2, 32'h0000BEEF, 1'b0, 0, "lhu_10");
        transact(1'b0, LB,  32'h10, 32'h0, 2, 32'hFFFFFFEF, 1'b0, 0, "lb_10");
        transact(1'b0, LBU, 32'h13, 32'h0, 2, 32'h000000DE, 1'b0, 0, "lbu_13");
        transact(1'b0, LHU, 32'h12, 32'h0, 2, 32'h0000DEAD, 1'b0, 0, "lhu_12");
        transact(1'b0, LH,  32'h10, 32'h0, 2, 32'hFFFFBEEF, 1'b0, 0, "lh_10");

        // Read-modify-write
        transact(1'b1, SW, 32'h20, 32'h11223344, 2, 32'h0, 1'b0, 0, "sw_20");
        transact(1'b1, SB, 32'h21, 32'h123456AA, 3, 32'h0, 1'b0, 0, "sb_21");
        transact(1'b0, LW, 32'h20, 32'h0, 2, 32'h1122AA44, 1'b0, 0, "lw_20a");
        transact(1'b1, SH, 32'h22, 32'hABCD5566, 3, 32'h0, 1'b0, 0, "sh_22");
        transact(1'b0, LW, 32'h20, 32'h0, 2, 32'h5566AA44, 1'b0, 0, "lw_20b");

        // Backpressure
        transact(1'b0, LW, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 5, "bp_lw");

        // Aliasing modulo 4*DEPTH bytes
        transact(1'b1, SW, 32'h0000, 32'h00000001, 2, 32'h0, 1'b0, 0, "sw_0");
        transact(1'b0, LW, 32'h1000, 32'h0, 2, 32'h00000001, 1'b0, 0, "lw_alias");

`ifdef DMEM_MISALIGN_FAULT_EN
        transact(1'b0, LW, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0, "lw_22_fault");
        transact(1'b1, SW, 32'h22, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, "sw_22_fault");
        transact(1'b1, SH, 32'h21, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, "sh_21_fault");
        transact(1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0, "ld_rsvd_fault");
        transact(1'b0, LW, 32'h20, 32'h0, 2, 32'h5566AA44, 1'b0, 0, "lw_20_intact");
`else
        transact(1'b0, LW, 32'h22, 32'h0, 2, 32'h5566AA44, 1'b0, 0, "lw_22_mis");
        transact(1'b0, LHU, 32'h23, 32'h0, 2, 32'h00005566, 1'b0, 0, "lhu_23_mis");
        transact(1'b0, 3'b011, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, "ld_rsvd");
        transact(1'b1, 3'b110, 32'h40, 32'hCAFEF00D, 2, 32'h0, 1'b0, 0, "st_rsvd");
        transact(1'b0, LW, 32'h40, 32'h0, 2, 32'hCAFEF00D, 1'b0, 0, "lw_40");
`endif

        // Reset while a load response is pending: response dropped
        start_req(1'b0, LW, 32'h10, 32'h0, 1'b0, "rst_resp");
        @(negedge clk);
        @(negedge clk);
        check("rst_resp.pending", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_resp");
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Reset during RMW_WR of SB 0xFF @0x30: write suppressed
        transact(1'b1, SW, 32'h30, 32'h00000000, 2, 32'h0, 1'b0, 0, "sw_30");
        start_req(1'b1, SB, 32'h30, 32'h000000FF, 1'b1, "rst_rmw");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rmw");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rmw.ready_after", {31'b0, req_ready}, 32'd1);
        transact(1'b0, LW, 32'h30, 32'h0, 2, 32'h00000000, 1'b0, 0, "lw_30");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
